// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared types and constants for the snake body tracker:
//               heading encoding, FSM state enum, empty-segment marker and
//               default board size.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

  typedef enum logic [1:0] {
    HD_UP    = 2'd0,
    HD_DOWN  = 2'd1,
    HD_LEFT  = 2'd2,
    HD_RIGHT = 2'd3
  } heading_t;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_CALC   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  localparam logic [31:0] EMPTY_SEG  = 32'hFFFF_FFFF;
  localparam int          GRID_W_DEF = 10;
  localparam int          GRID_H_DEF = 10;

  // Up/down and left/right differ only in bit 0, so a reverse request
  // shares bit 1 with the current heading and flips bit 0.
  function automatic logic is_reverse(input heading_t cur, input logic [1:0] req);
    return (req[1] == cur[1]) && (req[0] != cur[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_score_keeper.sv
`default_nettype none
// ============================================================================
// Module      : snake_score_keeper
// Description : Score and high-score registers. inc adds one point; clr
//               zeroes the score while keeping the high score. The high score
//               follows the score in the same cycle the score overtakes it.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_score_keeper (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        clr,
  output logic [31:0] score,
  output logic [31:0] high_score
);

  logic [31:0] score_inc;

  assign score_inc = score + 32'd1;

  // Score update; high score tracks the incremented value when it is larger
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      score      <= '0;
      high_score <= '0;
    end else if (clr) begin
      score <= '0;
    end else if (inc) begin
      score <= score_inc;
      if (score_inc > high_score) begin
        high_score <= score_inc;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/snake_body_tracker.sv
`default_nettype none
// ============================================================================
// Module      : snake_body_tracker
// Description : Holds the snake body as MAX_LEN (x,y) segments. Each step
//               computes the next head, scans the body one segment per cycle
//               for a self-hit, then shifts the body in a single commit cycle.
//               Optional macro SNAKE_WRAP_EN makes walls wrap instead of kill.
// Revision    : 1.0 - initial release
// ============================================================================
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int MAX_LEN   = 100,
  parameter int GRID_W    = GRID_W_DEF,
  parameter int GRID_H    = GRID_H_DEF,
  parameter int START_X   = 4,
  parameter int START_Y   = 5,
  parameter int START_LEN = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   step,
  input  logic [1:0]             dir,
  input  logic                   restart,
  input  logic [31:0]            food_x,
  input  logic [31:0]            food_y,
  output logic [32*MAX_LEN-1:0]  x_values,
  output logic [32*MAX_LEN-1:0]  y_values,
  output logic                   game_done,
  output logic [31:0]            score,
  output logic [31:0]            high_score,
  output logic                   food_eaten,
  output logic [31:0]            length
);

  localparam int          LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [31:0] GW    = 32'(GRID_W);
  localparam logic [31:0] GH    = 32'(GRID_H);

  state_t             state, state_nx;
  heading_t           heading;
  logic [31:0]        seg_x [MAX_LEN];
  logic [31:0]        seg_y [MAX_LEN];
  logic [LEN_W-1:0]   len_q;
  logic [31:0]        next_x, next_y;
  logic               grow;
  logic [LEN_W-1:0]   scan_idx, scan_last;

  logic [31:0]        cand_x, cand_y;
  logic [31:0]        calc_x, calc_y;
  logic               calc_oob;
  logic               calc_grow;
  logic [LEN_W-1:0]   scan_cnt;
  logic [31:0]        scan_x, scan_y;
  logic               scan_hit;
  logic               grow_full;
  logic               do_restart;
  logic               do_commit;

  // Raw next-head candidate: one tile along the heading axis, up is y-1
  always_comb begin
    cand_x = seg_x[0];
    cand_y = seg_y[0];
    case (heading)
      HD_UP:   cand_y = seg_y[0] - 32'd1;
      HD_DOWN: cand_y = seg_y[0] + 32'd1;
      HD_LEFT: cand_x = seg_x[0] - 32'd1;
      default: cand_x = seg_x[0] + 32'd1;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  // Wall handling: -1 (all ones) wraps to the far edge, GRID wraps to 0
  always_comb begin
    calc_x   = cand_x;
    calc_y   = cand_y;
    calc_oob = 1'b0;
    if (cand_x == EMPTY_SEG) calc_x = GW - 32'd1;
    else if (cand_x == GW)   calc_x = 32'd0;
    if (cand_y == EMPTY_SEG) calc_y = GH - 32'd1;
    else if (cand_y == GH)   calc_y = 32'd0;
  end
`else
  // Wall handling: unsigned compare also catches a decrement below zero
  always_comb begin
    calc_x   = cand_x;
    calc_y   = cand_y;
    calc_oob = (cand_x >= GW) || (cand_y >= GH);
  end
`endif

  assign calc_grow  = (calc_x == food_x) && (calc_y == food_y);
  // When not growing the tail slot vacates, so it is excluded from the scan
  assign scan_cnt   = calc_grow ? len_q : (len_q - LEN_W'(1));
  assign grow_full  = grow && (len_q == LEN_W'(MAX_LEN - 1));
  assign do_restart = (state == ST_DEAD) && restart;
  assign do_commit  = (state == ST_COMMIT);

  // Select the segment under scan without indexing by a wider counter
  always_comb begin
    scan_x = EMPTY_SEG;
    scan_y = EMPTY_SEG;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (scan_idx == LEN_W'(i)) begin
        scan_x = seg_x[i];
        scan_y = seg_y[i];
      end
    end
  end

  assign scan_hit = (next_x == scan_x) && (next_y == scan_y);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:    if (step) state_nx = ST_CALC;
      ST_CALC: begin
        if (calc_oob)                   state_nx = ST_DEAD;
        else if (scan_cnt == '0)        state_nx = ST_COMMIT;
        else                            state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        if (scan_hit)                   state_nx = ST_DEAD;
        else if (scan_idx == scan_last) state_nx = ST_COMMIT;
      end
      ST_COMMIT: state_nx = grow_full ? ST_DEAD : ST_RUN;
      ST_DEAD:   if (restart) state_nx = ST_RUN;
      default:   state_nx = ST_RUN;
    endcase
  end

  // Control/datapath registers: heading, candidate head, scan counter, length
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      heading    <= HD_RIGHT;
      next_x     <= '0;
      next_y     <= '0;
      grow       <= 1'b0;
      scan_idx   <= '0;
      scan_last  <= '0;
      len_q      <= LEN_W'(START_LEN);
      food_eaten <= 1'b0;
    end else begin
      food_eaten <= 1'b0;
      case (state)
        ST_RUN: begin
          if (step && !is_reverse(heading, dir)) heading <= heading_t'(dir);
        end
        ST_CALC: begin
          next_x    <= calc_x;
          next_y    <= calc_y;
          grow      <= calc_grow;
          scan_idx  <= '0;
          scan_last <= scan_cnt - LEN_W'(1);
        end
        ST_SCAN: scan_idx <= scan_idx + LEN_W'(1);
        ST_COMMIT: begin
          if (grow) begin
            len_q      <= len_q + LEN_W'(1);
            food_eaten <= 1'b1;
          end
        end
        ST_DEAD: begin
          if (restart) begin
            heading <= HD_RIGHT;
            len_q   <= LEN_W'(START_LEN);
          end
        end
        default: ;
      endcase
    end
  end

  // Body storage: reload on restart, shift by one on commit
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    localparam logic [31:0] INIT_X = (i < START_LEN) ? 32'(START_X - i) : EMPTY_SEG;
    localparam logic [31:0] INIT_Y = (i < START_LEN) ? 32'(START_Y)     : EMPTY_SEG;

    if (i == 0) begin : g_head
      // Head slot takes the scanned next head on commit
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          seg_x[i] <= INIT_X;
          seg_y[i] <= INIT_Y;
        end else if (do_restart) begin
          seg_x[i] <= INIT_X;
          seg_y[i] <= INIT_Y;
        end else if (do_commit) begin
          seg_x[i] <= next_x;
          seg_y[i] <= next_y;
        end
      end
    end else begin : g_body
      // Body slot takes its predecessor; the shifted-out old tail is cleared
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          seg_x[i] <= INIT_X;
          seg_y[i] <= INIT_Y;
        end else if (do_restart) begin
          seg_x[i] <= INIT_X;
          seg_y[i] <= INIT_Y;
        end else if (do_commit) begin
          if (!grow && (len_q == LEN_W'(i))) begin
            seg_x[i] <= EMPTY_SEG;
            seg_y[i] <= EMPTY_SEG;
          end else begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
        end
      end
    end

    assign x_values[32*i +: 32] = seg_x[i];
    assign y_values[32*i +: 32] = seg_y[i];
  end

  snake_score_keeper u_score (
    .clk        (clk),
    .reset      (reset),
    .inc        (do_commit && grow),
    .clr        (do_restart),
    .score      (score),
    .high_score (high_score)
  );

  assign game_done = (state == ST_DEAD);
  assign length    = 32'(len_q);

endmodule
`default_nettype wire

// File: tb/tb_snake_body_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_snake_body_tracker
// Description : Scoreboard bench for snake_body_tracker. A behavioural game
//               model queues expected snapshots as moves are driven; they are
//               popped and compared once the move has had time to complete.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_body_tracker;

  localparam int MAX_LEN   = 100;
  localparam int GRID_W    = 10;
  localparam int GRID_H    = 10;
  localparam int START_X   = 4;
  localparam int START_Y   = 5;
  localparam int START_LEN = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  step = 1'b0;
  logic [1:0]            dir = 2'd3;
  logic                  restart = 1'b0;
  logic [31:0]           food_x = 32'd0;
  logic [31:0]           food_y = 32'd0;
  logic [32*MAX_LEN-1:0] x_values;
  logic [32*MAX_LEN-1:0] y_values;
  logic                  game_done;
  logic [31:0]           score;
  logic [31:0]           high_score;
  logic                  food_eaten;
  logic [31:0]           length;

  always #5 clk = ~clk;

  snake_body_tracker #(
    .MAX_LEN   (MAX_LEN),
    .GRID_W    (GRID_W),
    .GRID_H    (GRID_H),
    .START_X   (START_X),
    .START_Y   (START_Y),
    .START_LEN (START_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .dir        (dir),
    .restart    (restart),
    .food_x     (food_x),
    .food_y     (food_y),
    .x_values   (x_values),
    .y_values   (y_values),
    .game_done  (game_done),
    .score      (score),
    .high_score (high_score),
    .food_eaten (food_eaten),
    .length     (length)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
  } seg_t;

  typedef struct {
    logic [31:0] hx, hy, s1x, s1y, s2x, s2y;
    logic [31:0] len, score, high, done, fe;
  } snap_t;

  seg_t  body[$];
  snap_t exp_q[$];
  int    m_head, m_len, m_score, m_high, fe_exp;
  bit    m_dead;
  int    fe_seen = 0;
  int    total = 0;
  int    bad = 0;

  always @(negedge clk) if (food_eaten === 1'b1) fe_seen++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bx(input int i);
    return (i < body.size()) ? body[i].x : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] by(input int i);
    return (i < body.size()) ? body[i].y : 32'hFFFF_FFFF;
  endfunction

  task automatic push_snap();
    snap_t s;
    s.hx = bx(0);  s.hy = by(0);
    s.s1x = bx(1); s.s1y = by(1);
    s.s2x = bx(2); s.s2y = by(2);
    s.len = 32'(m_len); s.score = 32'(m_score); s.high = 32'(m_high);
    s.done = {31'd0, m_dead}; s.fe = 32'(fe_exp);
    exp_q.push_back(s);
  endtask

  task automatic model_body_init();
    body.delete();
    for (int i = 0; i < START_LEN; i++) body.push_back('{x: 32'(START_X - i), y: 32'(START_Y)});
    m_head = 3; m_len = START_LEN; m_score = 0; m_dead = 1'b0;
  endtask

  task automatic model_reset();
    model_body_init();
    m_high = 0;
    push_snap();
  endtask

  task automatic model_restart();
    if (m_dead) model_body_init();
    push_snap();
  endtask

  task automatic model_step(input int d);
    int nx, ny, n;
    bit grow, hit;
    if (!m_dead) begin
      if ((d ^ m_head) != 1) m_head = d;
      nx = int'(body[0].x);
      ny = int'(body[0].y);
      case (m_head)
        0:       ny = ny - 1;
        1:       ny = ny + 1;
        2:       nx = nx - 1;
        default: nx = nx + 1;
      endcase
`ifdef SNAKE_WRAP_EN
      if (nx < 0) nx = GRID_W - 1;
      if (nx >= GRID_W) nx = 0;
      if (ny < 0) ny = GRID_H - 1;
      if (ny >= GRID_H) ny = 0;
`else
      if (nx < 0 || nx >= GRID_W || ny < 0 || ny >= GRID_H) m_dead = 1'b1;
`endif
      if (!m_dead) begin
        grow = (nx == int'(food_x)) && (ny == int'(food_y));
        n = grow ? m_len : m_len - 1;
        hit = 1'b0;
        for (int i = 0; i < n; i++)
          if (int'(body[i].x) == nx && int'(body[i].y) == ny) hit = 1'b1;
        if (hit) m_dead = 1'b1;
        else begin
          body.push_front('{x: 32'(nx), y: 32'(ny)});
          if (grow) begin
            m_len++; m_score++; fe_exp++;
            if (m_score > m_high) m_high = m_score;
            if (m_len == MAX_LEN) m_dead = 1'b1;
          end else begin
            void'(body.pop_back());
          end
        end
      end
    end
    push_snap();
  endtask

  task automatic compare_snap(input string tag);
    snap_t s;
    if (exp_q.size() == 0) begin
      $display("FAIL %s: scoreboard empty got=0 exp=1", tag);
      $fatal(1, "scoreboard underflow");
    end
    s = exp_q.pop_front();
    check_val({tag, "_hx"},   x_values[31:0],  s.hx);
    check_val({tag, "_hy"},   y_values[31:0],  s.hy);
    check_val({tag, "_s1x"},  x_values[63:32], s.s1x);
    check_val({tag, "_s1y"},  y_values[63:32], s.s1y);
    check_val({tag, "_s2x"},  x_values[95:64], s.s2x);
    check_val({tag, "_s2y"},  y_values[95:64], s.s2y);
    check_val({tag, "_len"},  length,          s.len);
    check_val({tag, "_scr"},  score,           s.score);
    check_val({tag, "_high"}, high_score,      s.high);
    check_val({tag, "_done"}, {31'd0, game_done}, s.done);
    check_val({tag, "_fe"},   32'(fe_seen),    s.fe);
  endtask

  task automatic drive_step(input int d);
    @(posedge clk); #1;
    step = 1'b1;
    dir  = 2'(d);
    @(posedge clk); #1;
    step = 1'b0;
  endtask

  task automatic do_move(input string tag, input int d);
    drive_step(d);
    model_step(d);
    repeat (10) @(posedge clk);
    @(negedge clk);
    compare_snap(tag);
  endtask

  task automatic do_restart(input string tag);
    @(posedge clk); #1;
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    model_restart();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_snap(tag);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    compare_snap(tag);
  endtask

  task automatic set_food(input int x, input int y);
    food_x = 32'(x);
    food_y = 32'(y);
  endtask

  initial begin
    fe_exp = 0;
    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare_snap("rst");
    check_val("rst_fe_level", {31'd0, food_eaten}, 32'd0);
    #1 reset = 1'b1;

    // One step right with exact commit latency (scan of one segment)
    drive_step(3);
    model_step(3);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("t1_before_commit_hx", x_values[31:0], 32'd4);
    @(posedge clk);
    @(negedge clk);
    compare_snap("t1");

    // Eat food at (6,5), then a plain move
    set_food(6, 5);
    do_move("t2_grow", 3);
    set_food(0, 0);
    do_move("t3_move", 3);

    // Reverse request is ignored
    do_move("t4_rev", 2);

    // Walk into the right wall
    do_move("t5_x9", 3);
    do_move("t6_wall", 3);
`ifndef SNAKE_WRAP_EN
    do_move("t7_dead_step", 3);
    do_restart("t8_restart");
`endif

    // Grow to length 5 and turn back into the body
    do_reset("t9_reset");
    set_food(5, 5); do_move("l1", 3);
    set_food(6, 5); do_move("l2", 3);
    set_food(7, 5); do_move("l3", 3);
    set_food(0, 0);
    do_move("l4_down", 1);
    do_move("l5_left", 2);
    do_move("l6_hit", 0);
    do_restart("l7_restart");

    // Reset asserted while scanning a growing move
    set_food(5, 5);
    drive_step(3);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    #2;
    compare_snap("r1_async");
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    push_snap();
    repeat (8) @(posedge clk);
    @(negedge clk);
    compare_snap("r2_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snake_body_tracker.md
SNAKE_BODY_TRACKER -- requirements
Module: snake_body_tracker

Interface
REQ-001 SHALL have parameter MAX_LEN, default 100, giving the segment capacity; bus width is 32*MAX_LEN.
REQ-002 SHALL have parameters GRID_W and GRID_H, default 10 each, giving the board size in tiles.
REQ-003 SHALL have parameters START_X, START_Y and START_LEN, defaults 4, 5 and 2, giving the initial head tile and initial length.
REQ-004 SHALL have port: clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port: reset  in  1  asynchronous, active-low reset; asserted when 0.
REQ-006 SHALL have port: step  in  1  one-cycle move tick.
REQ-007 SHALL have port: dir  in  2  requested heading: 0=up, 1=down, 2=left, 3=right.
REQ-008 SHALL have port: restart  in  1  leaves DEAD.
REQ-009 SHALL have ports: food_x, food_y  in  32 each  food tile.
REQ-010 SHALL have ports: x_values, y_values  out  32*MAX_LEN each  segment i at [32*i +: 32]; i=0 is head; unused segments are 32'hFFFFFFFF.
REQ-011 SHALL have port: game_done  out  1  high in DEAD.
REQ-012 SHALL have ports: score, high_score  out  32 each.
REQ-013 SHALL have port: food_eaten  out  1  one-cycle pulse requesting new food.
REQ-014 SHALL have port: length  out  32  live segment count.

Function
REQ-015 SHALL implement FSM states RUN, CALC, SCAN, COMMIT and DEAD.
REQ-016 In RUN, step=1 SHALL latch the heading and go to CALC; step in any other state SHALL be dropped.
REQ-017 A dir that is the exact reverse of the current heading SHALL be ignored, keeping the current heading.
REQ-018 CALC SHALL register next_head = head +/- 1 on the heading axis, with up meaning y-1.
REQ-019 In CALC, next_head outside 0..GRID_W-1 or 0..GRID_H-1 SHALL cause a transition to DEAD.
REQ-020 CALC SHALL set grow = (next_head == (food_x, food_y)).
REQ-021 SCAN SHALL compare next_head against one segment per cycle, from index 0 to length-1 when grow=1, or to length-2 when grow=0 (the tail vacates).
REQ-022 Any SCAN match SHALL cause a transition to DEAD at that cycle; otherwise SCAN SHALL go to COMMIT after the last index.
REQ-023 COMMIT SHALL shift segment i to i+1, write next_head into segment 0, and return to RUN.
REQ-024 When grow=0, COMMIT SHALL overwrite the old tail slot with 32'hFFFFFFFF.
REQ-025 When grow=1, COMMIT SHALL increment length and score, and pulse food_eaten for exactly that cycle.
REQ-026 Latency: outputs SHALL change on the clock edge that ends COMMIT, i.e. step edge + scanned_count + 2 cycles.
REQ-027 high_score SHALL update to score in the same cycle that score exceeds it.
REQ-028 When length reaches MAX_LEN, COMMIT SHALL go to DEAD.
REQ-029 In DEAD, restart=1 SHALL reload the initial body, set score to 0, keep high_score, and go to RUN; step SHALL be ignored in DEAD.
REQ-030 restart outside DEAD SHALL be ignored.
REQ-031 Arithmetic SHALL be 32-bit; a decrement from 0 yields 32'hFFFFFFFF, which SHALL be treated as out of bounds.

Reset
REQ-032 Reset SHALL take effect immediately, including mid-SCAN or mid-COMMIT, and force state RUN.
REQ-033 Reset values SHALL be: segment i at (START_X-i, START_Y) for i<START_LEN, all other segments 32'hFFFFFFFF, heading right, length=START_LEN.
REQ-034 Reset values SHALL be: score=0, high_score=0, game_done=0, food_eaten=0.

Configuration
REQ-035 SHALL use macro SNAKE_WRAP_EN: when defined, an out-of-bounds next_head wraps (-1 becomes GRID-1, GRID becomes 0) instead of killing.
REQ-036 When SNAKE_WRAP_EN is undefined, a wall hit SHALL go to DEAD.

Structure
REQ-037 Shared package snake_pkg SHALL hold the heading encoding, the FSM state enum, the EMPTY_SEG constant 32'hFFFFFFFF, and GRID defaults.
REQ-038 Score and high_score registers SHALL live in sub-module snake_score_keeper, with inputs inc and clr and outputs score and high_score.

Verification
REQ-039 Bench SHALL check: reset, then one step with dir=3 -> head (5,5), seg1 (4,5), seg2 empty, 4 cycles after step.
REQ-040 Bench SHALL check: food at (6,5), two steps right -> length=3, score=1, high_score=1, one food_eaten pulse.
REQ-041 Bench SHALL check: dir=2 while heading right -> ignored; head x increases.
REQ-042 Bench SHALL check: steps right from x=9 -> game_done=1, or x=0 when SNAKE_WRAP_EN is defined.
REQ-043 Bench SHALL check: a length-5 body looped into itself -> DEAD during SCAN; restart -> initial body, score=0, high_score retained.
REQ-044 Bench SHALL check: reset asserted mid-SCAN -> all outputs at reset values, with no food_eaten pulse.
